// File: rtl/src_pad_pkg.sv
// Shared constants, FSM state type and row-schedule helper for the source padder.
package src_pad_pkg;

  localparam int unsigned SRC_IMG_WIDTH  = 640;
  localparam int unsigned SRC_IMG_HEIGHT = 480;
  localparam int unsigned PIX_DW         = 24;
  localparam int unsigned PAD_PRE        = 1;
  localparam int unsigned PAD_POST       = 2;

  typedef enum logic {
    ST_PASS   = 1'b0,
    ST_REPLAY = 1'b1
  } pad_state_t;

  // Padded row r comes live from the source for r==0 and for rows 2..height;
  // the row after the first and the two trailing rows replay the line store.
  function automatic logic row_is_pass(input int unsigned row, input int unsigned height);
    return (row == 0) || ((row >= PAD_PRE + 1) && (row <= height + PAD_PRE - 1));
  endfunction

endpackage

// File: rtl/src_line_store.sv
// One-line pixel store: synchronous write, asynchronous read, no reset.
module src_line_store #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 24,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read port
  assign rdata = mem[addr];

endmodule

// File: rtl/src_pad.sv
// Border-replicating padder: WIDTH x HEIGHT raster in, (WIDTH+3) x (HEIGHT+3) out.
module src_pad
  import src_pad_pkg::*;
#(
  parameter int unsigned WIDTH  = SRC_IMG_WIDTH,
  parameter int unsigned HEIGHT = SRC_IMG_HEIGHT,
  parameter int unsigned DW     = PIX_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_eol,
  output logic          m_eof
);

  localparam int unsigned COL_LAST = WIDTH + PAD_PRE + PAD_POST - 1;
  localparam int unsigned ROW_LAST = HEIGHT + PAD_PRE + PAD_POST - 1;
  localparam int unsigned CW       = $clog2(COL_LAST + 1);
  localparam int unsigned RW       = $clog2(ROW_LAST + 1);
  localparam int unsigned AW       = $clog2(WIDTH);

  pad_state_t    state;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [DW-1:0] last_pix;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_rdata;
  logic [RW-1:0] row_next;
  logic          col_last;
  logic          row_last;
  logic          xfer;
  logic          wr_en;

  assign col_last = (col_cnt == CW'(COL_LAST));
  assign row_last = (row_cnt == RW'(ROW_LAST));
  assign xfer     = m_valid & m_ready;
  assign wr_en    = s_valid & s_ready;
  assign row_next = row_last ? '0 : row_cnt + RW'(1);
  assign m_eol    = m_valid & col_last;
  assign m_eof    = m_eol & row_last;

  // Line store address: source column clamped from the padded column
  always_comb begin
    st_addr = '0;
    if (col_cnt == '0) begin
      st_addr = '0;
    end else if (col_cnt > CW'(WIDTH)) begin
      st_addr = AW'(WIDTH - 1);
    end else begin
      st_addr = AW'(col_cnt - CW'(1));
    end
  end

  // Output mux and source handshake; the left pad peeks without consuming
  always_comb begin
    m_valid = 1'b0;
    m_data  = last_pix;
    s_ready = 1'b0;
    if (state == ST_PASS) begin
      if (col_cnt == '0) begin
        m_valid = s_valid;
        m_data  = s_data;
      end else if (col_cnt <= CW'(WIDTH)) begin
        m_valid = s_valid;
        m_data  = s_data;
        s_ready = m_ready;
      end else begin
        m_valid = 1'b1;
        m_data  = last_pix;
      end
    end else begin
      m_valid = 1'b1;
      m_data  = st_rdata;
    end
    if (rst) begin
      m_valid = 1'b0;
      s_ready = 1'b0;
    end
  end

  // FSM, counters and right-pad pixel: load-enabled, async-reset registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_PASS;
      col_cnt  <= '0;
      row_cnt  <= '0;
      last_pix <= '0;
    end else begin
      if (wr_en) last_pix <= s_data;
      if (xfer) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_next;
          state   <= row_is_pass(32'(row_next), HEIGHT) ? ST_PASS : ST_REPLAY;
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  src_line_store #(
    .DEPTH (WIDTH),
    .DW    (DW),
    .AW    (AW)
  ) u_line_store (
    .clk   (clk),
    .we    (wr_en),
    .addr  (st_addr),
    .wdata (s_data),
    .rdata (st_rdata)
  );

endmodule

// File: tb/tb_src_pad.sv
// Scoreboard bench for src_pad at WIDTH=4, HEIGHT=3, source pixel = 16*row+col.
`timescale 1ns/1ps
module tb_src_pad;

  localparam int W = 4;
  localparam int H = 3;
  localparam int NPIX = W * H;
  localparam int FRAME = (W + 3) * (H + 3);

  typedef struct packed {
    logic [23:0] data;
    logic        eol;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic        m_eol;
  logic        m_eof;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          beats_seen = 0;
  int          acc_seen = 0;
  int          eol_seen = 0;
  int          eof_seen = 0;
  int          src_idx = 0;
  logic        hold_pending = 1'b0;
  logic [23:0] held_data = '0;

  src_pad #(.WIDTH(W), .HEIGHT(H), .DW(24)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_eol   (m_eol),
    .m_eof   (m_eof)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix(input int idx);
    return 24'(16 * (idx / W) + (idx % W));
  endfunction

  // Hand-derived padded frame: source row/col chosen for each padded row/col
  task automatic push_frame();
    int rmap [6] = '{0, 0, 1, 2, 2, 2};
    int cmap [7] = '{0, 0, 1, 2, 3, 3, 3};
    beat_t b;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        b.data = 24'(16 * rmap[r] + cmap[c]);
        b.eol  = (c == 6);
        b.eof  = (c == 6) && (r == 5);
        exp_q.push_back(b);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stall stability
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      hold_pending <= 1'b0;
    end else begin
      if (m_valid) begin
        if (hold_pending) check("stall_stable", 32'(m_data), 32'(held_data));
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("m_data", 32'(m_data), 32'(e.data));
            check("m_eol", 32'(m_eol), 32'(e.eol));
            check("m_eof", 32'(m_eof), 32'(e.eof));
          end
          beats_seen++;
          if (m_eol) eol_seen++;
          if (m_eof) eof_seen++;
          hold_pending <= 1'b0;
        end else begin
          hold_pending <= 1'b1;
          held_data    <= m_data;
        end
      end
      if (s_valid && s_ready) acc_seen++;
    end
  end

  // Drive until n_beats transfers: optional ready toggling, source stall, reset pulse
  task automatic run(input int n_beats, input bit toggle, input int stall_at,
                     input int rst_at, input int budget, output int cycles);
    int  base = beats_seen;
    bit  ph = 1'b1;
    bit  fire;
    bit  stalled = 1'b0;
    bit  rst_done = 1'b0;
    cycles = 0;
    while ((beats_seen - base) < n_beats && cycles < budget) begin
      if (rst_at >= 0 && !rst_done && (beats_seen - base) == rst_at) begin
        rst_done = 1'b1;
        rst = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("rst_m_valid", 32'(m_valid), 32'd0);
          check("rst_s_ready", 32'(s_ready), 32'd0);
          @(posedge clk); #1;
        end
        rst = 1'b0;
        src_idx = 0;
        exp_q.delete();
        push_frame();
        base = beats_seen;
      end else if (stall_at >= 0 && !stalled && (beats_seen - base) == stall_at) begin
        stalled = 1'b1;
        for (int k = 0; k < 5; k++) begin
          s_valid = 1'b0; s_data = 24'hABCDEF; m_ready = 1'b1;
          @(negedge clk);
          check("stall_m_valid", 32'(m_valid), 32'd0);
          check("stall_s_ready", 32'(s_ready), 32'd0);
          @(posedge clk); #1;
        end
        check("stall_no_advance", 32'(beats_seen - base), 32'(stall_at));
      end else begin
        s_valid = 1'b1;
        s_data  = pix(src_idx);
        m_ready = toggle ? ph : 1'b1;
        ph      = ~ph;
        @(negedge clk);
        fire = s_valid && s_ready;
        @(posedge clk); #1;
        if (fire) src_idx = (src_idx + 1) % NPIX;
        cycles++;
      end
    end
    if ((beats_seen - base) < n_beats) check("timeout_beats", 32'(beats_seen - base), 32'(n_beats));
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    int a0, l0, f0, cyc;
    // Reset state with live inputs: outputs must stay quiet
    rst = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_m_valid", 32'(m_valid), 32'd0);
      check("reset_s_ready", 32'(s_ready), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;

    // Full frame, always ready
    a0 = acc_seen; l0 = eol_seen; f0 = eof_seen; src_idx = 0;
    push_frame();
    run(FRAME, 1'b0, -1, -1, 200, cyc);
    check("A_accepts", 32'(acc_seen - a0), 32'(NPIX));
    check("A_eols", 32'(eol_seen - l0), 32'd6);
    check("A_eofs", 32'(eof_seen - f0), 32'd1);
    check("A_cycles", 32'(cyc), 32'(FRAME));

    // Downstream ready toggling 1/0
    a0 = acc_seen; l0 = eol_seen; f0 = eof_seen; src_idx = 0;
    push_frame();
    run(FRAME, 1'b1, -1, -1, 400, cyc);
    check("B_accepts", 32'(acc_seen - a0), 32'(NPIX));
    check("B_eols", 32'(eol_seen - l0), 32'd6);
    check("B_eofs", 32'(eof_seen - f0), 32'd1);

    // Source stall at col 0 of source row 1 (after 14 padded beats)
    a0 = acc_seen; src_idx = 0;
    push_frame();
    run(FRAME, 1'b0, 14, -1, 200, cyc);
    check("C_accepts", 32'(acc_seen - a0), 32'(NPIX));

    // Reset after 17 beats, then a clean frame
    l0 = eol_seen; src_idx = 0;
    push_frame();
    run(FRAME, 1'b0, -1, 17, 300, cyc);
    f0 = eof_seen;
    check("D_queue_empty", 32'(exp_q.size()), 32'd0);

    // Two frames back to back: one transfer every cycle
    a0 = acc_seen; f0 = eof_seen; src_idx = 0;
    push_frame(); push_frame();
    run(2 * FRAME, 1'b0, -1, -1, 400, cyc);
    check("E_cycles", 32'(cyc), 32'(2 * FRAME));
    check("E_accepts", 32'(acc_seen - a0), 32'(2 * NPIX));
    check("E_eofs", 32'(eof_seen - f0), 32'd2);
    check("E_queue_empty", 32'(exp_q.size()), 32'd0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/src_pad.md
SRC_PAD -- requirements
Module: src_pad

Interface
REQ-001 The block SHALL have parameter WIDTH, default `SRC_IMG_WIDTH, source image width in pixels (>=2).
REQ-002 The block SHALL have parameter HEIGHT, default `SRC_IMG_HEIGHT, source image height in rows (>=2).
REQ-003 The block SHALL have parameter DW, default 24, pixel width (RGB888).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port s_valid, input, 1, raw source pixel valid.
REQ-007 The block SHALL have port s_ready, output, 1, raw pixel accepted when s_valid&s_ready.
REQ-008 The block SHALL have port s_data, input, DW, raw pixel, raster order.
REQ-009 The block SHALL have port m_valid, output, 1, padded pixel valid; it feeds the 4x4 window buffer's axi_valid.
REQ-010 The block SHALL have port m_ready, input, 1, downstream ready (window buffer axi_ready).
REQ-011 The block SHALL have port m_data, output, DW, padded pixel.
REQ-012 The block SHALL have port m_eol, output, 1, high with the last beat (col WIDTH+2) of each padded row.
REQ-013 The block SHALL have port m_eof, output, 1, high with the last beat of the padded frame.

Function
REQ-014 The block SHALL convert a WIDTH x HEIGHT raster into a (WIDTH+3) x (HEIGHT+3) border-replicated raster: 1 pad column/row before, 2 after.
REQ-015 Padded column c SHALL carry source column clamp(c-1, 0, WIDTH-1); padded row r SHALL carry source row clamp(r-1, 0, HEIGHT-1).
REQ-016 A beat SHALL transfer on m_valid&m_ready; col_cnt (0..WIDTH+2) and row_cnt (0..HEIGHT+2) SHALL advance only on a transfer, and col_cnt SHALL wrap to 0 with row_cnt+1.
REQ-017 The FSM SHALL have states PASS (data from s_data, written to line store) and REPLAY (data read from line store, s_ready=0).
REQ-018 The row sequence SHALL be: PASS src0, REPLAY src0, PASS src1..src(HEIGHT-1), REPLAY, REPLAY; after the eof beat the FSM SHALL return to PASS with both counters 0.
REQ-019 In PASS at col 0, m_valid SHALL equal s_valid, m_data SHALL equal s_data, and s_ready SHALL be 0 (left pad peeks without consuming).
REQ-020 In PASS at cols 1..WIDTH, m_valid=s_valid, m_data=s_data, s_ready=m_ready; each accepted pixel SHALL be written to line store address col-1 and into last_pix register.
REQ-021 In PASS at cols WIDTH+1, WIDTH+2, m_valid SHALL be 1, m_data=last_pix, s_ready=0.
REQ-022 In REPLAY, m_valid SHALL be 1, m_data SHALL be store[clamp(col-1,0,WIDTH-1)], s_ready=0.
REQ-023 Pass-through latency SHALL be zero (combinational s_data->m_data, m_ready->s_ready); no other combinational input-to-output paths are permitted.
REQ-024 Store writes SHALL occur only on an accepted source beat; a row SHALL never be overwritten while being replayed.
REQ-025 m_valid SHALL never drop without a transfer once asserted in pad/REPLAY beats; m_data SHALL stay stable while m_valid&~m_ready.
REQ-026 m_eol SHALL be asserted iff m_valid and col_cnt==WIDTH+2; m_eof iff m_eol and row_cnt==HEIGHT+2.

Reset
REQ-027 On rst, FSM SHALL enter PASS, col_cnt=0, row_cnt=0, last_pix=0; m_valid=0 and s_ready=0 while rst is high.
REQ-028 Reset mid-frame SHALL abandon the frame; the first source beat after release SHALL be treated as pixel (0,0). Line store contents are not reset.

Structure
REQ-029 Shared package/defines SHALL hold SRC_IMG_WIDTH, SRC_IMG_HEIGHT, pixel width 24 and pad constants (PAD_PRE=1, PAD_POST=2).
REQ-030 One sub-module SHALL be used: src_line_store (WIDTH x DW, sync write, async read); counters and FSM SHALL be built from dfflr/dffl cells.

Verification (WIDTH=4, HEIGHT=3, source pixel = 16*row+col)
REQ-031 Full frame, m_ready=1, s_valid=1 -> 42 beats; rows 0,1: 00 00 01 02 03 03 03; row 4,5: 20 20 21 22 23 23 23; 6 m_eol, 1 m_eof on beat 42.
REQ-032 m_ready toggled 1/0 each cycle -> identical 42-beat sequence; m_data stable during stalls; exactly 12 source beats accepted.
REQ-033 s_valid low for 5 cycles at col 0 of src row 1 -> m_valid low those cycles, no counter advance, s_ready=0, then 10 10 11 ...
REQ-034 rst pulsed after 17 output beats, then restart -> first output beats 00 00 01, counters at 0, no leftover eof.
REQ-035 Two back-to-back frames -> second frame output identical to first, no idle cycle required between eof and next 00.
